uart_apb_host: RTL



---
 rtl/uart_apb_host.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_apb_host.sv
// rtl/uart_apb_host.sv - APB3 register front end driving the UART core byte interface
//
// Purpose:
//   Bus responder between the system APB fabric and the UART core. It converts
//   register accesses into single-cycle push and pop strobes on the core's TX
//   and RX buffers. It inserts wait states while a buffer is full or empty,
//   owns the baud divisor register and raises a level interrupt.
//
// Register map (decoded on paddr[3:2], paddr[1:0] must be 0):
//   0x0 DATA   write pushes pwdata[7:0] to TX, read pops the RX head byte
//   0x4 STATUS bit0 rx_empty, bit1 tx_full, bit2 irq (read-only, writes ignored)
//   0x8 DIV    baud divisor [DIV_WIDTH-1:0]
//   0xC CTRL   bit0 rx_irq_en, bit1 tx_irq_en, bit2 block_en
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   psel .. pwdata        APB3 request inputs
//   prdata, pready,
//   pslverr               APB3 response outputs (registered)
//   w_data, wr_uart       TX buffer byte and push strobe
//   tx_full               TX buffer full
//   r_data, rd_uart       RX buffer head byte and pop strobe
//   rx_empty              RX buffer empty
//   timer_final_value     baud generator final value (mirrors DIV)
//   irq                   level interrupt (registered)

module uart_apb_host #(
  parameter int DIV_WIDTH = 11,
  parameter int DIV_RESET = 650,
  parameter int WAIT_MAX  = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [3:0]           paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [7:0]           w_data,
  output logic                 wr_uart,
  input  logic                 tx_full,
  input  logic [7:0]           r_data,
  output logic                 rd_uart,
  input  logic                 rx_empty,
  output logic [DIV_WIDTH-1:0] timer_final_value,
  output logic                 irq
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  // The stall counter starts at 0 on STALL entry, so this value marks the
  // last of WAIT_MAX stall cycles.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECIDE,
    S_STALL,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [WCW-1:0]       r_wait;
  logic [DIV_WIDTH-1:0] r_div;
  logic [2:0]           r_ctrl;
  logic [DIV_WIDTH-1:0] r_wdata;
  logic                 r_wr_div;
  logic                 r_wr_ctrl;

  logic                 w_addr_ok;
  logic                 w_is_data;
  logic                 w_data_rdy;
  logic [31:0]          w_rd_val;
  logic                 w_unused;

  assign w_addr_ok  = (paddr[1:0] == 2'b00);
  assign w_is_data  = (paddr[3:2] == 2'd0);
  // A DATA access can complete when its buffer has room (write) or a byte (read).
  assign w_data_rdy = pwrite ? ~tx_full : ~rx_empty;

  assign timer_final_value = r_div;

  // Upper write-data bits have no register behind them.
  assign w_unused = &{1'b0, pwdata[31:DIV_WIDTH]};

  // Read value for the non-DATA registers, sampled in the deciding cycle.
  always_comb begin
    w_rd_val = '0;
    case (paddr[3:2])
      2'd1:    w_rd_val[2:0] = {irq, tx_full, rx_empty};
      2'd2:    w_rd_val[DIV_WIDTH-1:0] = r_div;
      2'd3:    w_rd_val[2:0] = r_ctrl;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_div     <= DIV_WIDTH'(DIV_RESET);
      r_ctrl    <= '0;
      r_wdata   <= '0;
      r_wr_div  <= 1'b0;
      r_wr_ctrl <= 1'b0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      w_data    <= '0;
      wr_uart   <= 1'b0;
      rd_uart   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= (r_ctrl[0] & ~rx_empty) | (r_ctrl[1] & ~tx_full);

      // Response and strobes are single-cycle pulses; only the transition
      // into DONE raises them.
      pready  <= 1'b0;
      pslverr <= 1'b0;
      wr_uart <= 1'b0;
      rd_uart <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Entered on the setup phase so that the decision lands at the end
          // of the first access cycle, giving exactly one wait state.
          if (psel) begin
            r_state <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          if (!psel) begin
            r_state <= S_IDLE;
          end else if (penable) begin
            if (!w_addr_ok) begin
              r_state <= S_DONE;
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
            end else if (!w_is_data) begin
              r_state <= S_DONE;
              pready  <= 1'b1;
              if (pwrite) begin
                // Register writes commit on the edge that closes DONE.
                r_wdata   <= pwdata[DIV_WIDTH-1:0];
                r_wr_div  <= (paddr[3:2] == 2'd2);
                r_wr_ctrl <= (paddr[3:2] == 2'd3);
              end else begin
                prdata <= w_rd_val;
              end
            end else if (w_data_rdy) begin
              r_state <= S_DONE;
              pready  <= 1'b1;
              if (pwrite) begin
                wr_uart <= 1'b1;
                w_data  <= pwdata[7:0];
              end else begin
                rd_uart <= 1'b1;
                prdata  <= {24'h0, r_data};
              end
            end else if (r_ctrl[2]) begin
              r_state <= S_STALL;
              r_wait  <= '0;
            end else begin
              r_state <= S_DONE;
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
            end
          end
        end

        S_STALL: begin
          if (!psel) begin
            r_state <= S_IDLE;
          end else if (w_data_rdy) begin
            r_state <= S_DONE;
            pready  <= 1'b1;
            if (pwrite) begin
              wr_uart <= 1'b1;
              w_data  <= pwdata[7:0];
            end else begin
              rd_uart <= 1'b1;
              prdata  <= {24'h0, r_data};
            end
          end else if (r_wait == WAIT_LAST) begin
            r_state <= S_DONE;
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          if (r_wr_div) begin
            r_div <= r_wdata;
          end
          if (r_wr_ctrl) begin
            r_ctrl <= r_wdata[2:0];
          end
          r_wr_div  <= 1'b0;
          r_wr_ctrl <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
